// File: rtl/bexkat1_branch_unit_pkg.sv
// bexkat1Def: condition codes, CCR layout and the shared condition evaluator.
package bexkat1Def;

    typedef enum logic [3:0] {
        CondAlways = 4'd0,
        CondEq     = 4'd1,
        CondNe     = 4'd2,
        CondLtu    = 4'd3,
        CondGeu    = 4'd4,
        CondGtu    = 4'd5,
        CondLeu    = 4'd6,
        CondLt     = 4'd7,
        CondGe     = 4'd8,
        CondGt     = 4'd9,
        CondLe     = 4'd10,
        CondNever  = 4'd11
    } cond_t;

    // Field order makes the packed value read as {c,z,n,v}.
    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } ccr_t;

    // Codes 11..15 all fall into the default and evaluate false.
    function automatic logic cond_eval(cond_t cond, ccr_t ccr);
        logic lt;
        lt = ccr.n ^ ccr.v;
        case (cond)
            CondAlways: cond_eval = 1'b1;
            CondEq:     cond_eval = ccr.z;
            CondNe:     cond_eval = ~ccr.z;
            CondLtu:    cond_eval = ccr.c;
            CondGeu:    cond_eval = ~ccr.c;
            CondGtu:    cond_eval = ~ccr.c & ~ccr.z;
            CondLeu:    cond_eval = ccr.c | ccr.z;
            CondLt:     cond_eval = lt;
            CondGe:     cond_eval = ~lt;
            CondGt:     cond_eval = ~ccr.z & ~lt;
            CondLe:     cond_eval = ccr.z | lt;
            default:    cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bexkat1_branch_unit_target.sv
// Branch target adder: pc+4, plus the sign-extended word offset when taken.
module bexkat1_branch_unit_target #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OFFW  = 16
) (
    input  logic [WIDTH-1:0] i_pc,
    input  logic [OFFW-1:0]  i_off,
    input  logic             i_taken,
    output logic [WIDTH-1:0] o_target
);

    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_off_bytes;

    // Word offset -> byte offset; sums wrap modulo 2^WIDTH.
    always_comb begin
        w_seq       = i_pc + WIDTH'(4);
        w_off_bytes = {{(WIDTH-OFFW-2){i_off[OFFW-1]}}, i_off, 2'b00};
        o_target    = i_taken ? (w_seq + w_off_bytes) : w_seq;
    end

endmodule

// File: rtl/bexkat1_branch_unit.sv
// bexkat1 branch unit: CCR holder, branch resolver and one-entry result register.
// Optional macro BEXKAT1_CCR_BYPASS_EN forwards same-cycle flags into the evaluation
// instead of stalling the request for one cycle.
module bexkat1_branch_unit
    import bexkat1Def::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OFFW  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             flags_we_i,
    input  logic             c_i,
    input  logic             z_i,
    input  logic             n_i,
    input  logic             v_i,
    output logic [3:0]       ccr_o,
    input  logic             br_valid_i,
    output logic             br_ready_o,
    input  logic [3:0]       br_cond_i,
    input  logic [WIDTH-1:0] br_pc_i,
    input  logic [OFFW-1:0]  br_off_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             res_taken_o,
    output logic [WIDTH-1:0] res_target_o
);

    ccr_t             r_ccr;
    logic             r_valid;
    logic             r_taken;
    logic [WIDTH-1:0] r_target;

    ccr_t             w_ccr_new;
    ccr_t             w_ccr_eval;
    logic             w_taken;
    logic             w_accept;
    logic [WIDTH-1:0] w_target;

    // Evaluation CCR, handshake and condition resolution.
    always_comb begin
        w_ccr_new = '{c: c_i, z: z_i, n: n_i, v: v_i};
`ifdef BEXKAT1_CCR_BYPASS_EN
        w_ccr_eval = flags_we_i ? w_ccr_new : r_ccr;
        br_ready_o = ~r_valid | res_ready_i;
`else
        // Stall while the CCR is being written so the branch sees the settled value.
        w_ccr_eval = r_ccr;
        br_ready_o = (~r_valid | res_ready_i) & ~flags_we_i;
`endif
        w_accept = br_valid_i & br_ready_o;
        w_taken  = cond_eval(cond_t'(br_cond_i), w_ccr_eval);
    end

    bexkat1_branch_unit_target #(
        .WIDTH (WIDTH),
        .OFFW  (OFFW)
    ) u_target (
        .i_pc     (br_pc_i),
        .i_off    (br_off_i),
        .i_taken  (w_taken),
        .o_target (w_target)
    );

    // CCR load is independent of flush.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ccr <= '0;
        end else if (flags_we_i) begin
            r_ccr <= w_ccr_new;
        end
    end

    // Result register: flush wins, then accept (covers back-to-back), then drain.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid  <= 1'b0;
            r_taken  <= 1'b0;
            r_target <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_taken  <= w_taken;
            r_target <= w_target;
        end else if (res_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign ccr_o        = r_ccr;
    assign res_valid_o  = r_valid;
    assign res_taken_o  = r_taken;
    assign res_target_o = r_target;

endmodule

// File: tb/tb_bexkat1_branch_unit.sv
// Directed self-checking bench for bexkat1_branch_unit (either macro setting).
module tb_bexkat1_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        flags_we;
    logic        c, z, n, v;
    logic [3:0]  ccr;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_cond;
    logic [31:0] br_pc;
    logic [15:0] br_off;
    logic        res_valid;
    logic        res_ready;
    logic        res_taken;
    logic [31:0] res_target;

    int errors = 0;
    int checks = 0;

    bexkat1_branch_unit #(
        .WIDTH (32),
        .OFFW  (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .flush_i      (flush),
        .flags_we_i   (flags_we),
        .c_i          (c),
        .z_i          (z),
        .n_i          (n),
        .v_i          (v),
        .ccr_o        (ccr),
        .br_valid_i   (br_valid),
        .br_ready_o   (br_ready),
        .br_cond_i    (br_cond),
        .br_pc_i      (br_pc),
        .br_off_i     (br_off),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_taken_o  (res_taken),
        .res_target_o (res_target)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; flags_we = 0; {c, z, n, v} = 4'b0000;
        br_valid = 0; br_cond = 4'd0; br_pc = '0; br_off = '0; res_ready = 1'b1;
        #12;
        rst_n = 1'b1;
        tick();
        checks++; if (ccr !== 4'b0000) begin
            errors++; $display("FAIL reset_ccr got=%b exp=%b", ccr, 4'b0000); end
        checks++; if (res_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
        checks++; if (res_taken !== 1'b0 || res_target !== 32'h0) begin
            errors++; $display("FAIL reset_result got=%b/%h exp=0/0", res_taken, res_target); end
        checks++; if (br_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b exp=1", br_ready); end
    endtask

    // Flags of 5-7: c=1 z=0 n=1 v=0.
    task automatic test_ltu_ge();
        flags_we = 1; {c, z, n, v} = 4'b1010;
        tick();
        flags_we = 0; {c, z, n, v} = 4'b0000;
        checks++; if (ccr !== 4'b1010) begin
            errors++; $display("FAIL ccr_load got=%b exp=%b", ccr, 4'b1010); end
        br_valid = 1; br_cond = 4'd3; br_pc = 32'h100; br_off = 16'h0003;
        #1;
        checks++; if (br_ready !== 1'b1) begin
            errors++; $display("FAIL ltu_ready got=%b exp=1", br_ready); end
        tick();
        br_cond = 4'd8;
        checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_target !== 32'h110) begin
            errors++; $display("FAIL ltu_result got=%b/%b/%h exp=1/1/00000110",
                               res_valid, res_taken, res_target); end
        tick();
        br_valid = 0;
        checks++; if (res_valid !== 1'b1 || res_taken !== 1'b0 || res_target !== 32'h104) begin
            errors++; $display("FAIL ge_result got=%b/%b/%h exp=1/0/00000104",
                               res_valid, res_taken, res_target); end
        tick();
        checks++; if (res_valid !== 1'b0) begin
            errors++; $display("FAIL drain got=%b exp=0", res_valid); end
    endtask

    task automatic test_backpressure();
        res_ready = 0;
        br_valid = 1; br_cond = 4'd0; br_pc = 32'h200; br_off = 16'h0001;
        tick();
        // Next request held pending: EQ with z=0 -> not taken.
        br_cond = 4'd1; br_pc = 32'h300; br_off = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (br_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, br_ready); end
            checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_target !== 32'h208) begin
                errors++; $display("FAIL bp_hold[%0d] got=%b/%b/%h exp=1/1/00000208",
                                   i, res_valid, res_taken, res_target); end
            tick();
        end
        res_ready = 1;
        #1;
        checks++; if (br_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got=%b exp=1", br_ready); end
        tick();
        br_valid = 0;
        checks++; if (res_valid !== 1'b1 || res_taken !== 1'b0 || res_target !== 32'h304) begin
            errors++; $display("FAIL bp_next got=%b/%b/%h exp=1/0/00000304",
                               res_valid, res_taken, res_target); end
        tick();
    endtask

    // CCR currently z=0; write z=1 while an EQ branch is presented.
    task automatic test_flag_same_cycle();
        flags_we = 1; {c, z, n, v} = 4'b0100;
        br_valid = 1; br_cond = 4'd1; br_pc = 32'h400; br_off = 16'h0002;
        #1;
`ifdef BEXKAT1_CCR_BYPASS_EN
        checks++; if (br_ready !== 1'b1) begin
            errors++; $display("FAIL bypass_ready got=%b exp=1", br_ready); end
        tick();
        flags_we = 0; br_valid = 0;
`else
        checks++; if (br_ready !== 1'b0) begin
            errors++; $display("FAIL stall_ready got=%b exp=0", br_ready); end
        tick();
        flags_we = 0;
        #1;
        checks++; if (br_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL stall_retry got=%b/%b exp=1/0", br_ready, res_valid); end
        tick();
        br_valid = 0;
`endif
        checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_target !== 32'h40C) begin
            errors++; $display("FAIL same_cycle_eq got=%b/%b/%h exp=1/1/0000040c",
                               res_valid, res_taken, res_target); end
        tick();
    endtask

    task automatic test_flush();
        flags_we = 1; {c, z, n, v} = 4'b0011;
        br_valid = 1; br_cond = 4'd0; br_pc = 32'h500; br_off = 16'h0000;
        flush = 1;
        tick();
        flags_we = 0; flush = 0; br_valid = 0;
        checks++; if (res_valid !== 1'b0) begin
            errors++; $display("FAIL flush_accept got=%b exp=0", res_valid); end
        checks++; if (ccr !== 4'b0011) begin
            errors++; $display("FAIL flush_ccr got=%b exp=%b", ccr, 4'b0011); end
        // Flush of a result being held under backpressure.
        res_ready = 0; br_valid = 1;
        tick();
        br_valid = 0; flush = 1;
        tick();
        flush = 0; res_ready = 1;
        checks++; if (res_valid !== 1'b0) begin
            errors++; $display("FAIL flush_pending got=%b exp=0", res_valid); end
    endtask

    // CCR=0011 (n^v=0): taken mask over codes 0..15 computed by hand.
    task automatic test_cond_sweep();
        logic [15:0] exp_mask;
        exp_mask = 16'h0335;
        br_valid = 1; br_pc = 32'h1000; br_off = 16'h0010;
        for (int i = 0; i < 16; i++) begin
            br_cond = 4'(i);
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_taken !== exp_mask[i] ||
                res_target !== (exp_mask[i] ? 32'h1044 : 32'h1004)) begin
                errors++; $display("FAIL cond_%0d got=%b/%b/%h exp=1/%b/%h", i, res_valid,
                                   res_taken, res_target, exp_mask[i],
                                   exp_mask[i] ? 32'h1044 : 32'h1004); end
        end
        br_valid = 0;
        tick();
    endtask

    task automatic test_wrap();
        br_valid = 1; br_cond = 4'd0; br_pc = 32'hFFFF_FFFC; br_off = 16'h7FFF;
        tick();
        br_off = 16'h8000;
        checks++; if (res_target !== 32'h0001_FFFC) begin
            errors++; $display("FAIL wrap_pos got=%h exp=0001fffc", res_target); end
        tick();
        br_cond = 4'd12;
        checks++; if (res_target !== 32'hFFFE_0000) begin
            errors++; $display("FAIL wrap_neg got=%h exp=fffe0000", res_target); end
        tick();
        br_valid = 0;
        checks++; if (res_taken !== 1'b0 || res_target !== 32'h0) begin
            errors++; $display("FAIL never_wrap got=%b/%h exp=0/00000000", res_taken, res_target); end
    endtask

    task automatic test_reset_mid();
        flags_we = 1; {c, z, n, v} = 4'b1111;
        tick();
        flags_we = 0;
        br_valid = 1; br_cond = 4'd0; br_pc = 32'h2000; br_off = 16'h0001; res_ready = 0;
        tick();
        br_valid = 0;
        checks++; if (res_valid !== 1'b1 || ccr !== 4'b1111) begin
            errors++; $display("FAIL pre_reset got=%b/%b exp=1/1111", res_valid, ccr); end
        #1 rst_n = 0;
        #1;
        checks++; if (res_valid !== 1'b0 || res_taken !== 1'b0 || res_target !== 32'h0) begin
            errors++; $display("FAIL async_reset got=%b/%b/%h exp=0/0/00000000",
                               res_valid, res_taken, res_target); end
        checks++; if (ccr !== 4'b0000) begin
            errors++; $display("FAIL async_reset_ccr got=%b exp=0000", ccr); end
        #1 rst_n = 1; res_ready = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_ltu_ge();
        test_backpressure();
        test_flag_same_cycle();
        test_flush();
        test_cond_sweep();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
